// File: rtl/mpu_sequencer.sv
// mpu_sequencer
//   Microcode sequencer that feeds the 3-register MPU datapath. A small
//   writable program store of CW-bit control words is replayed onto the
//   control bus c, one word per cycle, after start. Supports hold (stall),
//   abort, one-shot and looping runs. c is NOP (all zero) whenever no word
//   is issued.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   prog_we/addr/data    program store write port (accepted only when idle)
//   start                begin execution (accepted only when idle)
//   last_addr, loop      run shape, latched on an accepted start
//   hold                 stall: NOP issued, pointer frozen
//   abort                terminate the current run immediately
//   c                    registered control word to the datapath
//   busy                 sequencer is not idle
//   done                 one-cycle pulse after a one-shot run completes
//   issued               words issued since the last start (wraps mod 256)
module mpu_sequencer #(
    parameter int AW    = 4,
    parameter int DEPTH = 2**AW,
    parameter int CW    = 9
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [CW-1:0] prog_data,
    input  logic          start,
    input  logic [AW-1:0] last_addr,
    input  logic          loop,
    input  logic          hold,
    input  logic          abort,
    output logic [CW-1:0] c,
    output logic          busy,
    output logic          done,
    output logic [7:0]    issued
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t        state_q;
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] last_q;
    logic          loop_q;
    logic [CW-1:0] c_q;
    logic          done_q;
    logic [7:0]    issued_q;
    logic [CW-1:0] mem_q [0:DEPTH-1];
    logic          wr_en_d;

    // Writes land only while idle. A write coinciding with an accepted
    // start still lands, so the first fetch (one edge later) sees it.
    assign wr_en_d = prog_we && (state_q == IDLE);

    // Program store is deliberately outside the reset domain: a reset in
    // the middle of a run keeps the loaded program intact.
    always_ff @(posedge clk) begin
        if (wr_en_d)
            mem_q[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            last_q   <= '0;
            loop_q   <= 1'b0;
            c_q      <= '0;
            done_q   <= 1'b0;
            issued_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    c_q    <= '0;
                    done_q <= 1'b0;
                    // abort has no meaning here; start always wins
                    if (start) begin
                        ptr_q    <= '0;
                        last_q   <= last_addr;
                        loop_q   <= loop;
                        issued_q <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    done_q <= 1'b0;
                    if (abort) begin
                        c_q     <= '0;
                        state_q <= IDLE;
                    end else if (hold) begin
                        c_q <= '0;
                    end else begin
                        c_q      <= mem_q[ptr_q];
                        issued_q <= issued_q + 8'd1;
                        if (ptr_q == last_q) begin
                            if (loop_q)
                                ptr_q <= '0;
                            else
                                state_q <= FINISH;
                        end else begin
                            ptr_q <= ptr_q + AW'(1);
                        end
                    end
                end
                FINISH: begin
                    // hold is ignored; only abort suppresses the done pulse
                    c_q     <= '0;
                    done_q  <= !abort;
                    state_q <= IDLE;
                end
                default: begin
                    c_q     <= '0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign c      = c_q;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign issued = issued_q;

endmodule

// File: tb/tb_mpu_sequencer.sv
module tb_mpu_sequencer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [8:0] prog_data = '0;
    logic       start = 1'b0;
    logic [3:0] last_addr = '0;
    logic       loop = 1'b0;
    logic       hold = 1'b0;
    logic       abort = 1'b0;
    logic [8:0] c;
    logic       busy;
    logic       done;
    logic [7:0] issued;

    int n_pass = 0;
    int n_total = 0;
    logic [8:0] shadow [16];

    mpu_sequencer #(.AW(4), .DEPTH(16), .CW(9)) dut (
        .clk(clk), .rstn(rstn),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .start(start), .last_addr(last_addr), .loop(loop),
        .hold(hold), .abort(abort),
        .c(c), .busy(busy), .done(done), .issued(issued)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [8:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
        shadow[a] = d;
    endtask

    task automatic start_run(input logic [3:0] l, input logic lp);
        last_addr = l; loop = lp; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_total++; if (c !== 9'h000) $display("FAIL reset_c got %h want 000", c); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_total++; if (issued !== 8'd0) $display("FAIL reset_issued got %0d want 0", issued); else n_pass++;
        rstn = 1'b1;
        tick();
        n_total++; if (busy !== 1'b0 || c !== 9'h000) $display("FAIL post_reset_idle busy=%b c=%h want 0/000", busy, c); else n_pass++;
    endtask

    task automatic test_oneshot();
        logic [8:0] exp [3];
        exp[0] = 9'h1C9; exp[1] = 9'h0B1; exp[2] = 9'h182;
        for (int k = 0; k < 3; k++) load(4'(k), exp[k]);
        start_run(4'd2, 1'b0);
        n_total++; if (busy !== 1'b1 || c !== 9'h000) $display("FAIL oneshot_E0 busy=%b c=%h want 1/000", busy, c); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++; if (c !== exp[k]) $display("FAIL oneshot_c E%0d got %h want %h", k+1, c, exp[k]); else n_pass++;
            n_total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL oneshot_busy E%0d busy=%b done=%b want 1/0", k+1, busy, done); else n_pass++;
        end
        tick();
        n_total++; if (c !== 9'h000 || done !== 1'b1 || busy !== 1'b0) $display("FAIL oneshot_finish c=%h done=%b busy=%b want 000/1/0", c, done, busy); else n_pass++;
        n_total++; if (issued !== 8'd3) $display("FAIL oneshot_issued got %0d want 3", issued); else n_pass++;
        tick();
        n_total++; if (done !== 1'b0) $display("FAIL oneshot_done_pulse got %b want 0", done); else n_pass++;
    endtask

    task automatic test_hold();
        start_run(4'd2, 1'b0);
        tick();
        n_total++; if (c !== 9'h1C9) $display("FAIL hold_E1 got %h want 1c9", c); else n_pass++;
        hold = 1'b1;
        tick();
        hold = 1'b0;
        n_total++; if (c !== 9'h000 || issued !== 8'd1 || busy !== 1'b1) $display("FAIL hold_stall c=%h issued=%0d busy=%b want 000/1/1", c, issued, busy); else n_pass++;
        tick();
        n_total++; if (c !== 9'h0B1) $display("FAIL hold_resume got %h want 0b1", c); else n_pass++;
        tick();
        n_total++; if (c !== 9'h182) $display("FAIL hold_last got %h want 182", c); else n_pass++;
        tick();
        n_total++; if (done !== 1'b1 || busy !== 1'b0 || issued !== 8'd3) $display("FAIL hold_finish done=%b busy=%b issued=%0d want 1/0/3", done, busy, issued); else n_pass++;
        tick();
    endtask

    task automatic test_loop_abort();
        start_run(4'd1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            n_total++; if (c !== shadow[i % 2] || busy !== 1'b1 || done !== 1'b0)
                $display("FAIL loop_c i%0d c=%h busy=%b done=%b want %h/1/0", i, c, busy, done, shadow[i % 2]); else n_pass++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_total++; if (c !== 9'h000 || busy !== 1'b0 || done !== 1'b0) $display("FAIL loop_abort c=%h busy=%b done=%b want 000/0/0", c, busy, done); else n_pass++;
        n_total++; if (issued !== 8'd6) $display("FAIL loop_issued got %0d want 6", issued); else n_pass++;
        tick();
        n_total++; if (done !== 1'b0) $display("FAIL loop_no_done got %b want 0", done); else n_pass++;
    endtask

    task automatic test_write_while_busy();
        start_run(4'd2, 1'b0);
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 9'h1FF;
        for (int i = 0; i < 4; i++) tick();
        prog_we = 1'b0;
        start_run(4'd2, 1'b0);
        tick();
        n_total++; if (c !== 9'h1C9) $display("FAIL busy_write_dropped got %h want 1c9", c); else n_pass++;
        tick(); tick(); tick();
        n_total++; if (done !== 1'b1) $display("FAIL busy_write_done got %b want 1", done); else n_pass++;
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 9'h155;
        last_addr = 4'd0; loop = 1'b0; start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        shadow[0] = 9'h155;
        tick();
        n_total++; if (c !== 9'h155) $display("FAIL write_with_start got %h want 155", c); else n_pass++;
        tick();
        n_total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL write_with_start_done done=%b busy=%b want 1/0", done, busy); else n_pass++;
    endtask

    task automatic test_async_reset();
        start_run(4'd2, 1'b0);
        tick(); tick();
        #2 rstn = 1'b0;
        #1;
        n_total++; if (c !== 9'h000 || busy !== 1'b0 || issued !== 8'd0 || done !== 1'b0)
            $display("FAIL async_reset c=%h busy=%b issued=%0d done=%b want 000/0/0/0", c, busy, issued, done); else n_pass++;
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        n_total++; if (busy !== 1'b0) $display("FAIL async_reset_idle busy=%b want 0", busy); else n_pass++;
        start_run(4'd2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++; if (c !== shadow[k]) $display("FAIL rerun_c E%0d got %h want %h", k+1, c, shadow[k]); else n_pass++;
        end
        tick();
        n_total++; if (done !== 1'b1 || issued !== 8'd3) $display("FAIL rerun_done done=%b issued=%0d want 1/3", done, issued); else n_pass++;
    endtask

    task automatic test_single_and_wrap();
        start_run(4'd0, 1'b0);
        tick();
        n_total++; if (c !== shadow[0] || busy !== 1'b1) $display("FAIL single_c c=%h busy=%b want %h/1", c, busy, shadow[0]); else n_pass++;
        tick();
        n_total++; if (c !== 9'h000 || done !== 1'b1 || busy !== 1'b0 || issued !== 8'd1)
            $display("FAIL single_done c=%h done=%b busy=%b issued=%0d want 000/1/0/1", c, done, busy, issued); else n_pass++;
        start_run(4'd3, 1'b1);
        for (int i = 0; i < 300; i++) tick();
        n_total++; if (issued !== 8'd44 || busy !== 1'b1) $display("FAIL wrap_issued issued=%0d busy=%b want 44/1", issued, busy); else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_total++; if (busy !== 1'b0 || done !== 1'b0 || issued !== 8'd44) $display("FAIL wrap_abort busy=%b done=%b issued=%0d want 0/0/44", busy, done, issued); else n_pass++;
    endtask

    // Model: a run is the word stream shadow[0..last] (repeated when looping);
    // each non-held cycle consumes the next word, then one FINISH cycle for
    // one-shot runs. abort ends everything at once. Inputs that must be
    // ignored while busy (start, writes, last/loop) are randomized throughout.
    task automatic test_random(input int iters);
        for (int it = 0; it < iters; it++) begin
            int lst, idx, cnt, cyc, limit;
            bit lp, fin, ab;
            logic [8:0] exp_c;
            logic exp_busy, exp_done;
            for (int a = 0; a < 16; a++) load(4'(a), 9'($urandom_range(1, 511)));
            lst = $urandom_range(0, 15);
            lp = ($urandom_range(0, 2) == 0);
            limit = $urandom_range(5, 60);
            idx = 0; cnt = 0; cyc = 0; fin = 1'b0;
            start_run(4'(lst), lp);
            while (!fin && cyc < 200) begin
                hold = ($urandom_range(0, 3) == 0);
                start = 1'($urandom);
                last_addr = 4'($urandom);
                loop = 1'($urandom);
                prog_we = 1'($urandom);
                prog_addr = 4'($urandom);
                prog_data = 9'($urandom);
                ab = lp ? (cyc >= limit) : ($urandom_range(0, 24) == 0);
                abort = ab;
                tick();
                cyc++;
                if (ab) begin
                    exp_c = 9'h000; exp_busy = 1'b0; exp_done = 1'b0; fin = 1'b1;
                end else if (!lp && idx > lst) begin
                    exp_c = 9'h000; exp_busy = 1'b0; exp_done = 1'b1; fin = 1'b1;
                end else if (hold) begin
                    exp_c = 9'h000; exp_busy = 1'b1; exp_done = 1'b0;
                end else begin
                    exp_c = shadow[idx]; exp_busy = 1'b1; exp_done = 1'b0;
                    cnt++; idx++;
                    if (lp && idx > lst) idx = 0;
                end
                n_total++; if (c !== exp_c || busy !== exp_busy || done !== exp_done)
                    $display("FAIL rand it%0d cyc%0d c=%h busy=%b done=%b want %h/%b/%b", it, cyc, c, busy, done, exp_c, exp_busy, exp_done); else n_pass++;
                n_total++; if (issued !== 8'(cnt % 256))
                    $display("FAIL rand_issued it%0d cyc%0d got %0d want %0d", it, cyc, issued, cnt % 256); else n_pass++;
            end
            hold = 1'b0; start = 1'b0; prog_we = 1'b0; abort = 1'b0;
            if (!fin) begin
                n_total++;
                $display("FAIL rand_timeout it%0d run did not end got busy=%b want 0", it, busy);
            end
            tick();
        end
    endtask

    initial begin
        for (int a = 0; a < 16; a++) shadow[a] = 9'h000;
        test_reset();
        test_oneshot();
        test_hold();
        test_loop_abort();
        test_write_while_busy();
        test_async_reset();
        test_single_and_wrap();
        test_random(20);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
